// File: rtl/bloque_cache_asoc.sv
// ---------------------------------------------------------------------------
// bloque_cache_asoc
//   Set-associative (1 or 2 ways), write-through, no-write-allocate cache,
//   one word per line, sitting between a core-side read/write port and a
//   slower backing memory reached through a req/ack handshake.
//
// Ports
//   clk           single clock, all logic on the rising edge
//   gen_reset     synchronous active-high reset
//   write_enable  core write request (sampled only when busy=0)
//   read_enable   core read request  (sampled only when busy=0)
//   adress        core word address
//   data_in       core write data
//   data_out      read data, held between reads
//   data_valid    one-cycle pulse, data_out valid for a read
//   hit           qualifies data_valid: 1 = served from cache
//   busy          miss/write transaction in flight; requests are dropped
//   mem_req       backing-memory request, held until mem_ack
//   mem_we        1 = memory write, 0 = memory read
//   mem_addr      memory address, stable while mem_req=1
//   mem_wdata     memory write data
//   mem_rdata     memory read data, valid with mem_ack
//   mem_ack       memory completion pulse
// ---------------------------------------------------------------------------
module bloque_cache_asoc #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 4,
    parameter int WAYS        = 2
) (
    input  logic                  clk,
    input  logic                  gen_reset,
    input  logic                  write_enable,
    input  logic                  read_enable,
    input  logic [ADDR_WIDTH-1:0] adress,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  hit,
    output logic                  busy,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack
);

    localparam int SETS      = 1 << INDEX_WIDTH;
    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_MEM  = 2'd2
    } state_t;

    state_t state, state_next;

    // Line storage. lru_q holds the number of the least-recently-used way.
    logic                  valid_q [WAYS][SETS];
    logic [TAG_WIDTH-1:0]  tag_q   [WAYS][SETS];
    logic [DATA_WIDTH-1:0] data_q  [WAYS][SETS];
    logic                  lru_q   [SETS];

    // Request decode: core address during IDLE, latched mem_addr during a miss.
    logic [INDEX_WIDTH-1:0] req_index;
    logic [TAG_WIDTH-1:0]   req_tag;
    logic [INDEX_WIDTH-1:0] miss_index;
    logic [TAG_WIDTH-1:0]   miss_tag;

    assign req_index  = adress[INDEX_WIDTH-1:0];
    assign req_tag    = adress[ADDR_WIDTH-1:INDEX_WIDTH];
    assign miss_index = mem_addr[INDEX_WIDTH-1:0];
    assign miss_tag   = mem_addr[ADDR_WIDTH-1:INDEX_WIDTH];

    assign busy = (state != IDLE);

    // Write wins over a simultaneous read; the read is simply dropped.
    logic accept_wr;
    logic accept_rd;

    assign accept_wr = (state == IDLE) && write_enable;
    assign accept_rd = (state == IDLE) && read_enable && !write_enable;

    // Tag lookup for the incoming request.
    logic lookup_hit;
    logic lookup_way;

    always_comb begin
        lookup_hit = 1'b0;
        lookup_way = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][req_index] && (tag_q[w][req_index] == req_tag)) begin
                lookup_hit = 1'b1;
                lookup_way = 1'(w);
            end
        end
    end

    // Refill victim: lowest-numbered invalid way, otherwise the LRU way.
    logic victim_way;

    always_comb begin
        victim_way = 1'b0;
        if (WAYS == 2 && valid_q[0][miss_index]) begin
            victim_way = valid_q[WAYS-1][miss_index] ? lru_q[miss_index] : 1'b1;
        end
    end

    // Next-state logic.
    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept_wr) begin
                    state_next = WR_MEM;
                end else if (accept_rd && !lookup_hit) begin
                    state_next = RD_MISS;
                end
            end
            RD_MISS: if (mem_ack) state_next = IDLE;
            WR_MEM:  if (mem_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (gen_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Control, status and bookkeeping bits (valid, LRU) that reset clears.
    always_ff @(posedge clk) begin
        if (gen_reset) begin
            for (int s = 0; s < SETS; s++) begin
                lru_q[s] <= 1'b0;
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[w][s] <= 1'b0;
                end
            end
            data_out   <= '0;
            data_valid <= 1'b0;
            hit        <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_wr) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= adress;
                        mem_wdata <= data_in;
                        if (lookup_hit && WAYS == 2) begin
                            lru_q[req_index] <= ~lookup_way;
                        end
                    end else if (accept_rd) begin
                        if (lookup_hit) begin
                            data_out   <= data_q[lookup_way][req_index];
                            data_valid <= 1'b1;
                            hit        <= 1'b1;
                            if (WAYS == 2) begin
                                lru_q[req_index] <= ~lookup_way;
                            end
                        end else begin
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= adress;
                        end
                    end
                end
                RD_MISS: begin
                    if (mem_ack) begin
                        valid_q[victim_way][miss_index] <= 1'b1;
                        if (WAYS == 2) begin
                            lru_q[miss_index] <= ~victim_way;
                        end
                        data_out   <= mem_rdata;
                        data_valid <= 1'b1;
                        hit        <= 1'b0;
                        mem_req    <= 1'b0;
                    end
                end
                WR_MEM: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

    // Tag/data arrays. Reset only has to block writes; contents are
    // meaningless until the matching valid bit is set.
    // NOTE: storage arrays are deliberately not reset; valid bits alone mark lines as empty.
    always_ff @(posedge clk) begin
        if (!gen_reset) begin
            if (accept_wr && lookup_hit) begin
                data_q[lookup_way][req_index] <= data_in;
            end else if (state == RD_MISS && mem_ack) begin
                tag_q[victim_way][miss_index]  <= miss_tag;
                data_q[victim_way][miss_index] <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_bloque_cache_asoc.sv
// ---------------------------------------------------------------------------
// tb_bloque_cache_asoc
//   Directed bench for bloque_cache_asoc: a 2-way instance driven by hand
//   with manual memory acks, plus a direct-mapped instance for the
//   single-way eviction case.
// ---------------------------------------------------------------------------
module tb_bloque_cache_asoc;

    logic        clk = 1'b0;
    logic        gen_reset = 1'b0;

    // 2-way instance
    logic        we = 1'b0, re = 1'b0;
    logic [9:0]  adr = '0;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic        dv, hit_o, busy_o, mreq, mwe;
    logic [9:0]  maddr;
    logic [31:0] mwdata;
    logic [31:0] mrdata = '0;
    logic        mack = 1'b0;

    // direct-mapped instance
    logic        w1_re = 1'b0;
    logic [9:0]  w1_adr = '0;
    logic [31:0] w1_dout;
    logic        w1_dv, w1_hit, w1_busy, w1_mreq, w1_mwe;
    logic [9:0]  w1_maddr;
    logic [31:0] w1_mwdata;
    logic [31:0] w1_rdata = '0;
    logic        w1_ack = 1'b0;

    int total = 0;
    int bad   = 0;
    logic [31:0] last_rd = '0;

    always #5 clk = ~clk;

    bloque_cache_asoc #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .INDEX_WIDTH(4), .WAYS(2)) dut (
        .clk(clk), .gen_reset(gen_reset),
        .write_enable(we), .read_enable(re), .adress(adr), .data_in(din),
        .data_out(dout), .data_valid(dv), .hit(hit_o), .busy(busy_o),
        .mem_req(mreq), .mem_we(mwe), .mem_addr(maddr), .mem_wdata(mwdata),
        .mem_rdata(mrdata), .mem_ack(mack)
    );

    bloque_cache_asoc #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .INDEX_WIDTH(4), .WAYS(1)) dut_w1 (
        .clk(clk), .gen_reset(gen_reset),
        .write_enable(1'b0), .read_enable(w1_re), .adress(w1_adr), .data_in(32'h0),
        .data_out(w1_dout), .data_valid(w1_dv), .hit(w1_hit), .busy(w1_busy),
        .mem_req(w1_mreq), .mem_we(w1_mwe), .mem_addr(w1_maddr), .mem_wdata(w1_mwdata),
        .mem_rdata(w1_rdata), .mem_ack(w1_ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_miss(input logic [9:0] a, input logic [31:0] rdata);
        re = 1'b1; adr = a;
        tick();
        re = 1'b0;
        check("miss_req", 32'(mreq), 32'd1);
        check("miss_we", 32'(mwe), 32'd0);
        check("miss_addr", 32'(maddr), 32'(a));
        check("miss_busy", 32'(busy_o), 32'd1);
        check("miss_dv_early", 32'(dv), 32'd0);
        tick();
        tick();
        check("miss_hold_req", 32'(mreq), 32'd1);
        mack = 1'b1; mrdata = rdata;
        tick();
        mack = 1'b0;
        check("fill_dv", 32'(dv), 32'd1);
        check("fill_data", dout, rdata);
        check("fill_hit", 32'(hit_o), 32'd0);
        check("fill_busy", 32'(busy_o), 32'd0);
        check("fill_req", 32'(mreq), 32'd0);
        last_rd = rdata;
        tick();
        check("fill_dv_pulse", 32'(dv), 32'd0);
    endtask

    task automatic read_hit(input logic [9:0] a, input logic [31:0] exp);
        re = 1'b1; adr = a;
        tick();
        re = 1'b0;
        check("hit_dv", 32'(dv), 32'd1);
        check("hit_flag", 32'(hit_o), 32'd1);
        check("hit_data", dout, exp);
        check("hit_req", 32'(mreq), 32'd0);
        check("hit_busy", 32'(busy_o), 32'd0);
        last_rd = exp;
    endtask

    task automatic write_txn(input logic [9:0] a, input logic [31:0] d, input logic also_read);
        we = 1'b1; re = also_read; adr = a; din = d;
        tick();
        we = 1'b0; re = 1'b0;
        check("wr_req", 32'(mreq), 32'd1);
        check("wr_we", 32'(mwe), 32'd1);
        check("wr_addr", 32'(maddr), 32'(a));
        check("wr_wdata", mwdata, d);
        check("wr_busy", 32'(busy_o), 32'd1);
        check("wr_no_dv", 32'(dv), 32'd0);
        check("wr_dout_held", dout, last_rd);
        tick();
        mack = 1'b1;
        tick();
        mack = 1'b0;
        check("wr_done_req", 32'(mreq), 32'd0);
        check("wr_done_we", 32'(mwe), 32'd0);
        check("wr_done_busy", 32'(busy_o), 32'd0);
        check("wr_done_no_dv", 32'(dv), 32'd0);
    endtask

    task automatic w1_read(input logic [9:0] a, input logic exp_hit, input logic [31:0] d);
        w1_re = 1'b1; w1_adr = a;
        tick();
        w1_re = 1'b0;
        if (!exp_hit) begin
            check("w1_miss_req", 32'(w1_mreq), 32'd1);
            tick();
            w1_ack = 1'b1; w1_rdata = d;
            tick();
            w1_ack = 1'b0;
        end
        check("w1_dv", 32'(w1_dv), 32'd1);
        check("w1_hit", 32'(w1_hit), 32'(exp_hit));
        check("w1_data", w1_dout, d);
    endtask

    initial begin
        gen_reset = 1'b1;
        tick();
        tick();
        gen_reset = 1'b0;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_req", 32'(mreq), 32'd0);
        check("rst_we", 32'(mwe), 32'd0);
        check("rst_addr", 32'(maddr), 32'd0);
        check("rst_wdata", mwdata, 32'd0);
        check("rst_dout", dout, 32'd0);
        check("rst_dv", 32'(dv), 32'd0);
        check("rst_hit", 32'(hit_o), 32'd0);

        // Direct-mapped: 0x013 shares set 3 with 0x003 and evicts it.
        w1_read(10'h003, 1'b0, 32'h503);
        w1_read(10'h003, 1'b1, 32'h503);
        w1_read(10'h013, 1'b0, 32'h513);
        w1_read(10'h003, 1'b0, 32'h603);

        // Basic miss then hit.
        read_miss(10'h003, 32'hAB);
        read_hit(10'h003, 32'hAB);

        // Write miss does not allocate; write hit updates the line.
        write_txn(10'h011, 32'd15, 1'b0);
        read_miss(10'h011, 32'h51);
        write_txn(10'h003, 32'd25, 1'b0);
        read_hit(10'h003, 32'd25);

        // Set 3 conflict: 0x003 (way0), 0x013 (way1); touching 0x003 leaves 0x013 LRU.
        read_miss(10'h013, 32'h13D);
        read_hit(10'h003, 32'd25);
        read_miss(10'h023, 32'h23E);
        read_hit(10'h003, 32'd25);
        read_miss(10'h013, 32'h13F);

        // Simultaneous write and read: only the write happens.
        write_txn(10'h02C, 32'd25, 1'b1);
        read_miss(10'h02C, 32'h2C0);

        // Request while busy is ignored.
        re = 1'b1; adr = 10'h005;
        tick();
        re = 1'b0;
        check("ign_req", 32'(mreq), 32'd1);
        re = 1'b1; adr = 10'h041;
        tick();
        re = 1'b0;
        check("ign_addr", 32'(maddr), 32'h005);
        check("ign_no_dv", 32'(dv), 32'd0);
        check("ign_dout_held", dout, last_rd);
        mack = 1'b1; mrdata = 32'h555;
        tick();
        mack = 1'b0;
        check("ign_fill_dv", 32'(dv), 32'd1);
        check("ign_fill_data", dout, 32'h555);
        last_rd = 32'h555;
        tick();
        check("ign_no_extra_dv", 32'(dv), 32'd0);
        check("ign_no_extra_req", 32'(mreq), 32'd0);

        // Reset during RD_MISS aborts; a late ack is ignored.
        re = 1'b1; adr = 10'h007;
        tick();
        re = 1'b0;
        check("abort_req", 32'(mreq), 32'd1);
        tick();
        gen_reset = 1'b1;
        tick();
        gen_reset = 1'b0;
        check("abort_req_low", 32'(mreq), 32'd0);
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_dout", dout, 32'd0);
        last_rd = '0;
        mack = 1'b1; mrdata = 32'hDEAD;
        tick();
        mack = 1'b0;
        check("late_ack_dv", 32'(dv), 32'd0);
        check("late_ack_req", 32'(mreq), 32'd0);
        check("late_ack_busy", 32'(busy_o), 32'd0);
        check("late_ack_dout", dout, 32'd0);

        // Reset invalidated every line; all-ones address lands in set 15.
        read_miss(10'h003, 32'h33);
        read_miss(10'h3FF, 32'hFF);
        read_hit(10'h3FF, 32'hFF);
        read_miss(10'h00F, 32'h0F);
        read_hit(10'h3FF, 32'hFF);
        read_hit(10'h00F, 32'h0F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bloque_cache_asoc.md
Name: bloque_cache_asoc

Overview:
Parametrised successor to the single-cycle cache block: an N-way (1 or 2) set-associative, write-through, no-write-allocate cache, one word per line. It sits between the core-side read/write port and a slower backing memory reached through a req/ack handshake. It adds hit/miss detection, miss refill, LRU replacement, and a busy flag that the core-side port does not have today.

Parameters:
ADDR_WIDTH, 10, word address width of adress and mem_addr
DATA_WIDTH, 32, data word width
INDEX_WIDTH, 4, set index bits; 2**INDEX_WIDTH sets; must be < ADDR_WIDTH
WAYS, 2, associativity; legal values 1 or 2

Ports:
clk  in  1  single clock; all logic on rising edge
gen_reset  in  1  reset; synchronous, active-high
write_enable  in  1  write request; sampled only when busy=0
read_enable  in  1  read request; sampled only when busy=0
adress  in  ADDR_WIDTH  request word address
data_in  in  DATA_WIDTH  write data
data_out  out  DATA_WIDTH  read data; held between reads
data_valid  out  1  one-cycle pulse, data_out valid for a read
hit  out  1  qualifies data_valid: 1 = served from cache
busy  out  1  cache in a miss/write transaction; requests ignored
mem_req  out  1  backing-memory request, held until mem_ack
mem_we  out  1  1 = memory write, 0 = memory read
mem_addr  out  ADDR_WIDTH  memory address, stable while mem_req=1
mem_wdata  out  DATA_WIDTH  memory write data
mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_ack
mem_ack  in  1  memory completion, one-cycle pulse

Behaviour:
- Address split: index = adress[INDEX_WIDTH-1:0]; tag = adress[ADDR_WIDTH-1:INDEX_WIDTH].
- Per set and way: valid bit, tag, data. Per set: one LRU bit (WAYS=2 only).
- Reset is synchronous on gen_reset=1 and overrides everything:
  - clears all valid and LRU bits; state=IDLE.
  - data_out, data_valid, hit, busy, mem_req, mem_we, mem_addr and mem_wdata all go to 0.
- Reset mid-transaction aborts: mem_req low the cycle after reset; no line is written; a late mem_ack is ignored.
- States are IDLE, RD_MISS and WR_MEM; busy=1 in any state other than IDLE.
- IDLE, request accepted on the edge where busy=0 and (read_enable or write_enable):
  - if both enables are high, write has priority and the read is dropped.
  - Read hit: next cycle data_out = line data, data_valid=1, hit=1; LRU marks the hit way most-recent; stay IDLE. Latency is 1 cycle, with back-to-back hits every cycle.
  - Read miss: next cycle state=RD_MISS, busy=1, mem_req=1, mem_we=0, mem_addr=latched adress.
  - Write, hit or miss: next cycle state=WR_MEM, busy=1, mem_req=1, mem_we=1, mem_addr/mem_wdata latched.
  - On a write hit, the cached line is updated on the accept edge and LRU is updated. A write miss allocates nothing.
- RD_MISS: hold mem_req and mem_addr until mem_ack=1 is sampled. On that edge:
  - victim = lowest-numbered invalid way, else the LRU way; victim is written with valid=1, tag and mem_rdata; LRU marks the victim most-recent.
  - next cycle: data_out=mem_rdata, data_valid=1, hit=0, mem_req=0, busy=0, state=IDLE.
- WR_MEM: hold until mem_ack; next cycle mem_req=0, mem_we=0, busy=0, IDLE. data_valid is not pulsed.
- Requests while busy=1 are ignored and not queued.
- mem_ack in IDLE is ignored.
- Memory latency is unbounded; there is no timeout.
- WAYS=1: direct-mapped; always replace way 0; LRU logic is absent.
- Boundaries:
  - adress=all-ones maps to index 2**INDEX_WIDTH-1 with the maximum tag; no wrap into another set.
  - data_out keeps its last value after a write or an ignored request.

Test Plan:
- Defaults; reset, then read 0x003 -> miss. Cycle+1: mem_req=1, mem_we=0, mem_addr=0x003. Ack 3 cycles later with rdata=0xAB -> data_valid pulse, data_out=0xAB, hit=0, busy=0. Reread 0x003 -> 1-cycle data_valid, hit=1, mem_req stays 0.
- Write 0x011 with data 15 (miss) -> mem_req=1, mem_we=1, mem_wdata=15 until ack. Later read 0x011 -> miss (no allocate). Write 0x003 with 25 (hit) -> later read 0x003 hits, data_out=25.
- Set conflict at index 3:
  - fill 0x003 and 0x013, then read 0x003 (hit).
  - read 0x023 -> miss evicts 0x013.
  - then 0x003 hits and 0x013 misses.
  - WAYS=1 rerun: 0x013 fill evicts 0x003.
- Same-edge write_enable=read_enable=1 at 0x02C with data 25 -> write transaction only (mem_we=1), no data_valid; read 0x02C afterwards -> miss (no allocate).
- Pulse read_enable at 0x041 while busy=1 -> ignored: no mem_addr change, no extra data_valid.
- Assert gen_reset during RD_MISS before ack -> next cycle mem_req=0, busy=0; a subsequent ack causes nothing. Read 0x3FF -> miss fills set 15; reread hits.
